// File: rtl/upg_pkg.sv
// Shared types and sizing for the UART upgrade loader.
// The optional checksum stage (UPG_LOADER_CHECKSUM_EN) uses the S_CHK encoding.
package upg_pkg;

    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned DEFAULT_DEPTH  = 16384;
    localparam int unsigned DEFAULT_ADDR_W = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_BYTE  = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Little-endian 8-to-32 packer: byte k of a word lands in bits [8k+7:8k].
module word_packer
    import upg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word,
    output logic              word_full_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx;

    assign word_full_c = push && (idx == IDX_W'(BYTES_PER_WORD - 1));

    // Shift right so the first byte ends up in the low lane after a full word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (push) begin
            word <= {din, word[WORD_W-1:8]};
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/upg_loader.sv
// UART-driven instruction-memory loader: length header, word packing, write strobes.
// Define UPG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module upg_loader
    import upg_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_n_i,
    input  logic              start_i,
    input  logic [7:0]        rx_dat_i,
    input  logic              rx_vld_i,
    output logic              rx_rdy_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [WORD_W-1:0] upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] word_cnt_o
);

    localparam int unsigned LEN_W = 17;
    localparam int unsigned TO_W  = 24;
`ifdef UPG_LOADER_CHECKSUM_EN
    localparam state_t END_ST = S_CHK;
`else
    localparam state_t END_ST = S_DONE;
`endif

    state_t           state;
    state_t           next_state;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [TO_W-1:0]  to_cnt;
    logic             accept_c;
    logic             sess_start_c;
    logic             timed_c;
    logic             timeout_c;
    logic             word_full_c;
    logic [LEN_W-1:0] len_hdr_c;
    logic [LEN_W-1:0] cnt_inc_c;
`ifdef UPG_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept_c     = rx_vld_i && rx_rdy_o;
    assign sess_start_c = start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign timed_c      = (state == S_LEN0) || (state == S_LEN1) || (state == S_BYTE) || (state == S_CHK);
    assign timeout_c    = (TIMEOUT_CYC != '0) && (to_cnt == TIMEOUT_CYC - TO_W'(1));
    assign len_hdr_c    = {1'b0, rx_dat_i, len_lo};
    assign cnt_inc_c    = LEN_W'(word_cnt_o) + LEN_W'(1);

    word_packer u_packer (
        .clk         (upg_clk_i),
        .rst_n       (upg_rst_n_i),
        .clr         (sess_start_c),
        .push        (accept_c && state == S_BYTE),
        .din         (rx_dat_i),
        .word        (upg_dat_o),
        .word_full_c (word_full_c)
    );

    // State register; status outputs are registered decodes of the next state.
    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            state      <= S_IDLE;
            rx_rdy_o   <= 1'b0;
            upg_wen_o  <= 1'b0;
            busy_o     <= 1'b0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= next_state;
            rx_rdy_o   <= (next_state == S_LEN0) || (next_state == S_LEN1) ||
                          (next_state == S_BYTE) || (next_state == S_CHK);
            upg_wen_o  <= (next_state == S_WRITE);
            busy_o     <= !((next_state == S_IDLE) || (next_state == S_DONE) || (next_state == S_ERR));
            upg_done_o <= (next_state == S_DONE);
            err_o      <= (next_state == S_ERR);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (start_i) next_state = S_LEN0;
            S_LEN0: begin
                if (accept_c)       next_state = S_LEN1;
                else if (timeout_c) next_state = S_ERR;
            end
            S_LEN1: begin
                if (accept_c) begin
                    if (len_hdr_c == '0)                 next_state = END_ST;
                    else if (len_hdr_c > LEN_W'(DEPTH))  next_state = S_ERR;
                    else                                 next_state = S_BYTE;
                end else if (timeout_c) begin
                    next_state = S_ERR;
                end
            end
            S_BYTE: begin
                if (word_full_c)                 next_state = S_WRITE;
                else if (!accept_c && timeout_c) next_state = S_ERR;
            end
            S_WRITE: next_state = (cnt_inc_c == {1'b0, len}) ? END_ST : S_BYTE;
`ifdef UPG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_c)       next_state = (rx_dat_i == csum) ? S_DONE : S_ERR;
                else if (timeout_c) next_state = S_ERR;
            end
`endif
            S_DONE, S_ERR: if (start_i) next_state = S_LEN0;
            default: next_state = S_IDLE;
        endcase
    end

    // Session datapath: header capture, address/count, inactivity timer.
    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            len_lo     <= '0;
            len        <= '0;
            upg_adr_o  <= '0;
            word_cnt_o <= '0;
            to_cnt     <= '0;
        end else begin
            if (sess_start_c) begin
                upg_adr_o  <= '0;
                word_cnt_o <= '0;
            end else if (state == S_WRITE) begin
                upg_adr_o  <= upg_adr_o + ADDR_W'(1);
                word_cnt_o <= word_cnt_o + ADDR_W'(1);
            end
            if (accept_c && state == S_LEN0) len_lo <= rx_dat_i;
            if (accept_c && state == S_LEN1) len    <= len_hdr_c[15:0];
            if (timed_c && !accept_c && !sess_start_c) to_cnt <= to_cnt + TO_W'(1);
            else                                       to_cnt <= '0;
        end
    end

`ifdef UPG_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; header bytes are excluded.
    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i)                   csum <= '0;
        else if (sess_start_c)              csum <= '0;
        else if (accept_c && state == S_BYTE) csum <= csum ^ rx_dat_i;
    end
`endif

endmodule
